// File: rtl/ctrl_seq_decoder.sv
// ctrl_seq_decoder: programmable opcode-to-control-beat sequencer with valid/ready on both sides
module ctrl_seq_decoder #(
  parameter int OP_W   = 7,
  parameter int CTRL_W = 26,
  parameter int CNT_W  = 3,
  parameter int DONE_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_we,
  input  logic [OP_W-1:0]         cfg_addr,
  input  logic [CTRL_W+CNT_W-1:0] cfg_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [OP_W-1:0]         in_op,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CTRL_W-1:0]       out_ctrl,
  output logic [CNT_W-1:0]        out_step,
  output logic                    out_last,
  output logic                    busy,
  output logic [DONE_W-1:0]       done_cnt
);
  typedef enum logic {IDLE, RUN} state_t;
  localparam int ENT_W = CTRL_W + CNT_W;
  logic [ENT_W-1:0]  tbl_q [2**OP_W];
  logic [ENT_W-1:0]  entry;
  state_t            state_q, state_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [CNT_W-1:0]  len_q, len_d, step_q, step_d, step_inc;
  logic              last_q, last_d;
  logic [DONE_W-1:0] done_q, done_d;
  logic              accept, fire, finish, advance;
  // Accept/advance decisions and next-state values; table read happens before any same-cycle write lands
  always_comb begin
    entry    = tbl_q[in_op];
    fire     = (state_q == RUN) && out_ready;
    finish   = fire && last_q;
    advance  = fire && !last_q;
    in_ready = (state_q == IDLE) || finish;
    accept   = in_valid && in_ready;
    step_inc = step_q + 1'b1;
    state_d  = accept ? RUN : (finish ? IDLE : state_q);
    ctrl_d   = accept ? entry[CTRL_W-1:0] : ctrl_q;
    len_d    = accept ? entry[ENT_W-1:CTRL_W] : len_q;
    step_d   = accept ? '0 : (advance ? step_inc : step_q);
    last_d   = accept ? (entry[ENT_W-1:CTRL_W] == '0) : (advance ? (step_inc == len_q) : last_q);
    done_d   = finish ? done_q + DONE_W'(1) : done_q;
  end
  // Sequencer state, latched entry and completion counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ctrl_q  <= '0;
      len_q   <= '0;
      step_q  <= '0;
      last_q  <= 1'b0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      len_q   <= len_d;
      step_q  <= step_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end
  // Decode table storage, cleared to single-beat zero entries on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**OP_W; i++) tbl_q[i] <= '0;
    end else if (cfg_we) begin
      tbl_q[cfg_addr] <= cfg_data;
    end
  end
  assign out_valid = (state_q == RUN);
  assign busy      = (state_q == RUN);
  assign out_ctrl  = ctrl_q;
  assign out_step  = step_q;
  assign out_last  = last_q;
  assign done_cnt  = done_q;
endmodule

// File: doc/ctrl_seq_decoder.md
Name: ctrl_seq_decoder

Overview:
- Parametrised, sequential successor to the fixed 7-input/26-output combinational control decoder.
- Accepts opcodes over a valid/ready handshake and looks each one up in a programmable decode table.
- Each table entry holds a control word and a step count; one opcode expands into 1..2^CNT_W registered control beats on a valid/ready output.
- Sits between instruction fetch and the datapath control inputs.

Parameters:
OP_W, 7, opcode width; the table has 2^OP_W entries
CTRL_W, 26, control word width
CNT_W, 3, step-count width; an entry issues len+1 beats
DONE_W, 16, completed-operation counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
cfg_we  in  1  table write strobe
cfg_addr  in  OP_W  table write address
cfg_data  in  CTRL_W+CNT_W  entry value; {len[CNT_W-1:0], ctrl[CTRL_W-1:0]}, len in the MSBs
in_valid  in  1  opcode valid
in_ready  out  1  opcode accepted when in_valid && in_ready
in_op  in  OP_W  opcode
out_valid  out  1  control beat valid
out_ready  in  1  downstream accepts the beat
out_ctrl  out  CTRL_W  control word of the latched entry
out_step  out  CNT_W  index of the current beat, 0..len
out_last  out  1  high when out_step == len
busy  out  1  high in RUN
done_cnt  out  DONE_W  count of completed operations

Behaviour:
- Reset (asynchronous, takes effect immediately): state=IDLE; out_valid=0, out_ctrl=0, out_step=0, out_last=0, busy=0, done_cnt=0.
- Reset also clears all table entries to 0 (ctrl=0, len=0, i.e. one beat). in_ready is 1 in reset state.
- Table write: on a clk edge with cfg_we=1, table[cfg_addr] <= cfg_data. Writes are legal in any state.
- Table read is read-before-write: an opcode accepted in the same cycle as a write to its address latches the old entry.
- The latched entry of a running operation is never affected by later writes.
- FSM states: IDLE, RUN.
- in_ready = (state==IDLE) || (out_valid && out_ready && out_last). The combinational path from out_ready to in_ready is permitted.
- IDLE: on accept, latch table[in_op] into the ctrl and len registers, set out_step=0 and go to RUN.
  - out_valid rises the cycle after accept (latency 1).
- RUN: out_valid=1, busy=1. out_ctrl, out_step and out_last hold stable while !out_ready.
- RUN, out_ready && !out_last: out_step <= out_step+1.
- RUN, out_ready && out_last:
  - done_cnt <= done_cnt+1, wrapping at 2^DONE_W.
  - If in_valid: accept back-to-back, latch the new entry, out_step=0, stay in RUN, with no bubble cycle.
  - Else: go to IDLE; out_valid=0 next cycle; out_ctrl holds its last value.
- len = 2^CNT_W-1 issues 2^CNT_W beats; out_step never wraps within an operation.
- in_op is sampled only on accept; in_op changes while in_ready=0 have no effect.
- Reset mid-operation: the beat is dropped, no done_cnt increment, the table returns to all zeros, and the FSM restarts in IDLE.

Test Plan:
- Reset with no writes; send in_op=7'h05 with out_ready=1 -> one beat next cycle: out_ctrl=0, out_step=0, out_last=1; done_cnt=1; then out_valid=0.
- Write table[7'h12]={3'd2, 26'h2AAAAAA}; send op 7'h12 with out_ready=1 -> 3 consecutive beats with out_ctrl=26'h2AAAAAA, out_step 0,1,2, out_last only on step 2; in_ready=0 for the first two beats.
- Same op with out_ready low for 4 cycles at step 1 -> out_step holds at 1 and out_ctrl is unchanged; on release, steps 1 and 2 complete and done_cnt increments once.
- Back-to-back: op A (len=0) then op B (len=1), with in_valid held and out_ready=1 -> beats A0, B0, B1 on consecutive cycles with no idle cycle; done_cnt +2.
- Same-cycle write and accept to address 7'h30 (old len=0, ctrl=1; new ctrl=26'h3FFFFFF) -> the beat carries ctrl=1; the next accept of 7'h30 carries 26'h3FFFFFF.
- Reset asserted during step 3 of a len=7 op -> out_valid, busy and out_step go to 0 immediately without waiting for clk; done_cnt=0; after reset, the previously programmed opcode reads ctrl=0, len=0.
